program_loader: RTL and testbench

- Writer side of the TD4 program store: accepts a 16-byte program image over a valid/ready byte stream and writes it into a writable 16x8 program RAM.
- The RAM read port (A in, D out) is presented to the CPU exactly as the program memory is.
- Holds the CPU in reset (CPU_HOLD) while loading, optionally verifies a checksum, and reports DONE/ERROR.
- Sits between the host byte receiver (UART RX, outside this block) and the TD4 core.

---
 rtl/td4_defs.sv | 46 ++++
 rtl/prog_ram.sv | 29 ++
 rtl/program_loader.sv | 136 +++++++++++++
 tb/tb_program_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/td4_defs.sv
// Shared TD4 definitions: word sizes, loader state encoding, and the
// registered output set the loader FSM drives for each state.
package td4_defs;

    localparam int         TD4_ADDR_W = 4;
    localparam int         TD4_DATA_W = 8;
    localparam logic [7:0] TD4_NOP    = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } load_state_t;

    typedef struct packed {
        logic in_ready;
        logic busy;
        logic cpu_hold;
        logic done;
        logic error;
    } load_outs_t;

    // Output set for a given state; registered alongside the state so every
    // status output changes on the same edge as the state itself.
    function automatic load_outs_t outs_for(load_state_t s);
        load_outs_t o;
        o = '0;
        case (s)
            ST_LOAD, ST_CHECK: begin
                o.in_ready = 1'b1;
                o.busy     = 1'b1;
                o.cpu_hold = 1'b1;
            end
            ST_DONE:  o.done = 1'b1;
            ST_ERROR: begin
                o.cpu_hold = 1'b1;
                o.error    = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Writable program store: 2**ADDR_W x DATA_W registers, one synchronous
// write port, asynchronous read, cleared to NOP (all zeros) on reset.
module prog_ram
    import td4_defs::*;
#(
    parameter int ADDR_W = TD4_ADDR_W,
    parameter int DATA_W = TD4_DATA_W
) (
    input  logic              CLK,
    input  logic              N_RESET,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D
);

    logic [2**ADDR_W-1:0][DATA_W-1:0] mem;

    // Clear every word on reset, otherwise write one word per enabled edge
    always_ff @(posedge CLK) begin
        if (!N_RESET) mem <= '0;
        else if (we)  mem[waddr] <= wdata;
    end

    // Read sees the pre-edge contents, so a same-cycle write shows old data
    assign D = mem[A];

endmodule

// File: rtl/program_loader.sv
// TD4 program loader: streams a 16-byte image into prog_ram over a
// valid/ready byte interface, holding the CPU in reset while loading.
// Optional build macro PROGLOAD_CHECKSUM_EN adds a 17th checksum byte
// (mod-256 sum of the image) verified in the CHECK state.
module program_loader
    import td4_defs::*;
#(
    parameter int ADDR_W         = TD4_ADDR_W,
    parameter int DATA_W         = TD4_DATA_W,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              CLK,
    input  logic              N_RESET,
    input  logic              START,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic              CPU_HOLD,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR
);

    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    load_state_t        state;
    load_outs_t         outs;
    logic [ADDR_W-1:0]  ptr;
    logic [TO_W-1:0]    to_cnt;
    logic [DATA_W-1:0]  ram_d;
    logic               xfer;
    logic               timed_out;
`ifdef PROGLOAD_CHECKSUM_EN
    logic [DATA_W-1:0]  sum;
`endif

    assign xfer      = IN_VALID & outs.in_ready;
    assign timed_out = TO_EN && (to_cnt == TO_LAST);

    // Loader FSM: pointer, checksum, idle-cycle counter and registered status
    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            state  <= ST_IDLE;
            outs   <= '0;
            ptr    <= '0;
            to_cnt <= '0;
`ifdef PROGLOAD_CHECKSUM_EN
            sum    <= '0;
`endif
        end else begin
            case (state)
                ST_LOAD: begin
                    if (xfer) begin
                        ptr    <= ptr + ADDR_W'(1);
                        to_cnt <= '0;
`ifdef PROGLOAD_CHECKSUM_EN
                        sum    <= sum + IN_DATA;
`endif
                        if (ptr == '1) begin
`ifdef PROGLOAD_CHECKSUM_EN
                            state <= ST_CHECK;
                            outs  <= outs_for(ST_CHECK);
`else
                            state <= ST_DONE;
                            outs  <= outs_for(ST_DONE);
`endif
                        end
                    end else if (timed_out) begin
                        state <= ST_ERROR;
                        outs  <= outs_for(ST_ERROR);
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
`ifdef PROGLOAD_CHECKSUM_EN
                ST_CHECK: begin
                    if (xfer) begin
                        to_cnt <= '0;
                        if (IN_DATA == sum) begin
                            state <= ST_DONE;
                            outs  <= outs_for(ST_DONE);
                        end else begin
                            state <= ST_ERROR;
                            outs  <= outs_for(ST_ERROR);
                        end
                    end else if (timed_out) begin
                        state <= ST_ERROR;
                        outs  <= outs_for(ST_ERROR);
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
`endif
                // IDLE, DONE, ERROR: wait for START; START during a load is ignored
                default: begin
                    if (START) begin
                        state  <= ST_LOAD;
                        outs   <= outs_for(ST_LOAD);
                        ptr    <= '0;
                        to_cnt <= '0;
`ifdef PROGLOAD_CHECKSUM_EN
                        sum    <= '0;
`endif
                    end
                end
            endcase
        end
    end

    prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .we      (xfer && (state == ST_LOAD)),
        .waddr   (ptr),
        .wdata   (IN_DATA),
        .A       (A),
        .D       (ram_d)
    );

    // CPU sees NOPs while the image is in flux
    assign D        = outs.busy ? DATA_W'(TD4_NOP) : ram_d;
    assign IN_READY = outs.in_ready;
    assign BUSY     = outs.busy;
    assign CPU_HOLD = outs.cpu_hold;
    assign DONE     = outs.done;
    assign ERROR    = outs.error;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the driver pushes the expected
// DONE/ERROR outcome and its edge number; a negedge monitor pops and
// compares when the DUT raises DONE or ERROR. RAM contents are compared
// against an image array kept by the bench.
module tb_program_loader;

    localparam int TO = 20;

    logic       CLK = 1'b0;
    logic       N_RESET = 1'b0;
    logic       START = 1'b0;
    logic [7:0] IN_DATA = 8'h00;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [3:0] A = 4'h0;
    logic [7:0] D;
    logic       CPU_HOLD, BUSY, DONE, ERROR;

    program_loader #(
        .ADDR_W         (4),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK      (CLK),
        .N_RESET  (N_RESET),
        .START    (START),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .A        (A),
        .D        (D),
        .CPU_HOLD (CPU_HOLD),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERROR    (ERROR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int edge_no;
    } outcome_t;

    outcome_t   exp_q[$];
    outcome_t   o;
    int         n_checks = 0;
    int         n_fail = 0;
    int         outcomes_seen = 0;
    int         n_exp = 0;
    int         last_edge = 0;
    logic [7:0] model [16];
    bit         prev_done = 1'b0;
    bit         prev_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every DONE/ERROR rise must match the next expected outcome
    always @(negedge CLK) begin
        if ((DONE && !prev_done) || (ERROR && !prev_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_outcome", 32'd1, 32'd0);
            end else begin
                o = exp_q.pop_front();
                chk("outcome_done",  {31'd0, DONE},     {31'd0, !o.is_err});
                chk("outcome_error", {31'd0, ERROR},    {31'd0, o.is_err});
                chk("outcome_hold",  {31'd0, CPU_HOLD}, {31'd0, o.is_err});
                chk("outcome_busy",  {31'd0, BUSY},     32'd0);
                chk("outcome_edge",  cyc,               o.edge_no);
            end
            outcomes_seen++;
        end
        prev_done = DONE;
        prev_err  = ERROR;
    end

    task automatic start_load();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("ready_after_start", {31'd0, IN_READY}, 32'd1);
        chk("busy_after_start",  {31'd0, BUSY},     32'd1);
        chk("hold_after_start",  {31'd0, CPU_HOLD}, 32'd1);
    endtask

    // Entered and left at a negedge; records the edge number of the transfer
    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse, input bit probe);
        int g;
        IN_VALID = 1'b0;
        repeat (gap) @(negedge CLK);
        if (probe) begin
            A = 4'($urandom);
            #1;
            chk("d_zero_busy", {24'd0, D}, 32'd0);
        end
        if (gap == 0) chk("ready_held", {31'd0, IN_READY}, 32'd1);
        IN_VALID = 1'b1;
        IN_DATA  = b;
        START    = pulse;
        g = 0;
        while (!IN_READY && g < 50) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 50) begin
            chk("ready_wait", 32'd0, 32'd1);
            IN_VALID = 1'b0;
            START    = 1'b0;
            return;
        end
        last_edge = cyc + 1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        START    = 1'b0;
        IN_DATA  = 8'($urandom);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 16; a++) begin
            A = 4'(a);
            #1;
            chk(tag, {24'd0, D}, {24'd0, model[a]});
            @(negedge CLK);
        end
    endtask

    task automatic wait_out(input int n);
        int t;
        t = 0;
        while (outcomes_seen < n && t < 100) begin
            @(negedge CLK);
            t++;
        end
        chk("outcome_arrived", outcomes_seen, n);
    endtask

    task automatic do_reset();
        N_RESET = 1'b0;
        repeat (2) @(negedge CLK);
        N_RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic load_image(input bit rnd_data, input bit rnd_gaps, input bit bad_sum);
        int   gap;
        bit   pulse;
`ifdef PROGLOAD_CHECKSUM_EN
        logic [7:0] s;
        s = 8'h00;
`endif
        for (int i = 0; i < 16; i++) model[i] = rnd_data ? 8'($urandom) : 8'(i + 1);
        start_load();
        for (int i = 0; i < 16; i++) begin
            gap   = !rnd_gaps ? 0 : ((i == 7) ? TO - 1 : int'($urandom_range(0, TO - 1)));
            pulse = rnd_gaps && ($urandom_range(0, 3) == 0);
            send_byte(model[i], gap, pulse, rnd_gaps);
`ifdef PROGLOAD_CHECKSUM_EN
            s = s + model[i];
`endif
        end
`ifdef PROGLOAD_CHECKSUM_EN
        send_byte(bad_sum ? s - 8'd1 : s, 0, 1'b0, 1'b0);
`endif
        exp_q.push_back('{bad_sum, last_edge});
        n_exp++;
        wait_out(n_exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset and idle
        do_reset();
        chk("idle_ready", {31'd0, IN_READY}, 32'd0);
        chk("idle_busy",  {31'd0, BUSY},     32'd0);
        chk("idle_hold",  {31'd0, CPU_HOLD}, 32'd0);
        chk("idle_done",  {31'd0, DONE},     32'd0);
        chk("idle_error", {31'd0, ERROR},    32'd0);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        sweep("reset_mem");

        // Good load 01..10 with IN_VALID held high
        load_image(1'b0, 1'b0, 1'b0);
        chk("good_ready_low", {31'd0, IN_READY}, 32'd0);
        A = 4'd5;
        #1;
        chk("good_a5", {24'd0, D}, 32'h06);
        @(negedge CLK);
        sweep("good_mem");

`ifdef PROGLOAD_CHECKSUM_EN
        // Bad checksum, then recovery from ERROR with a fresh START
        load_image(1'b0, 1'b0, 1'b1);
        chk("bad_error", {31'd0, ERROR},    32'd1);
        chk("bad_done",  {31'd0, DONE},     32'd0);
        chk("bad_hold",  {31'd0, CPU_HOLD}, 32'd1);
        sweep("bad_mem");
        load_image(1'b1, 1'b0, 1'b0);
        chk("recover_error", {31'd0, ERROR}, 32'd0);
        sweep("recover_mem");
`endif

        // Random data, random gaps (one at the timeout boundary), stray STARTs
        for (int k = 0; k < 3; k++) begin
            load_image(1'b1, 1'b1, 1'b0);
            sweep("gap_mem");
        end

        // Timeout: 3 bytes then silence
        do_reset();
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        start_load();
        for (int i = 0; i < 3; i++) begin
            model[i] = 8'($urandom_range(1, 255));
            send_byte(model[i], 0, 1'b0, 1'b0);
        end
        exp_q.push_back('{1'b1, last_edge + TO});
        n_exp++;
        for (int k = 0; k < 4; k++) begin
            A = 4'($urandom);
            #1;
            chk("to_d_zero", {24'd0, D}, 32'd0);
            @(negedge CLK);
        end
        wait_out(n_exp);
        chk("to_error", {31'd0, ERROR},    32'd1);
        chk("to_hold",  {31'd0, CPU_HOLD}, 32'd1);
        sweep("to_mem");

        // Reset mid-load after 8 bytes
        start_load();
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0, 1'b0, 1'b0);
        N_RESET = 1'b0;
        @(negedge CLK);
        N_RESET = 1'b1;
        chk("rst_busy",  {31'd0, BUSY},     32'd0);
        chk("rst_hold",  {31'd0, CPU_HOLD}, 32'd0);
        chk("rst_ready", {31'd0, IN_READY}, 32'd0);
        chk("rst_done",  {31'd0, DONE},     32'd0);
        chk("rst_error", {31'd0, ERROR},    32'd0);
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        sweep("rst_mem");
        load_image(1'b1, 1'b0, 1'b0);
        sweep("final_mem");
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
